// File: rtl/sparrow_pkg.sv
// Shared types and constants for the sparrow data-memory responder.
// Access sizes follow the core's byte_en encoding; 2'b10 is treated as a word.
package sparrow_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b11
  } dmem_size_e;

  localparam logic [2:0] MMIO_MTIME_LO    = 3'd0;
  localparam logic [2:0] MMIO_MTIME_HI    = 3'd1;
  localparam logic [2:0] MMIO_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] MMIO_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] MMIO_TOHOST      = 3'd4;
  localparam logic [2:0] MMIO_STATUS      = 3'd5;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      default: bad = (lane != 2'b00);
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << lane;
      SZ_HALF: m = 4'b0011 << lane;
      default: m = 4'hF;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {4{data[7:0]}};
      SZ_HALF: r = {2{data[15:0]}};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sparrow_mtimer.sv
// 64-bit machine timer with compare; a half-write loads that half and skips
// the increment for that cycle. The interrupt is registered from last cycle's values.
module sparrow_mtimer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_mtime_lo_i,
  input  logic        wr_mtime_hi_i,
  input  logic        wr_cmp_lo_i,
  input  logic        wr_cmp_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] mtime_o,
  output logic [63:0] mtimecmp_o,
  output logic        irq_o
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic        irq_q, irq_d;

  always_comb begin
    mtime_d = mtime_q + 64'd1;
    if (wr_mtime_lo_i) begin
      mtime_d = {mtime_q[63:32], wdata_i};
    end else if (wr_mtime_hi_i) begin
      mtime_d = {wdata_i, mtime_q[31:0]};
    end
  end

  always_comb begin
    cmp_d = cmp_q;
    if (wr_cmp_lo_i) begin
      cmp_d[31:0] = wdata_i;
    end
    if (wr_cmp_hi_i) begin
      cmp_d[63:32] = wdata_i;
    end
  end

  assign irq_d = (mtime_q >= cmp_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mtime_q <= 64'd0;
      cmp_q   <= '1;
      irq_q   <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      irq_q   <= irq_d;
    end
  end

  assign mtime_o    = mtime_q;
  assign mtimecmp_o = cmp_q;
  assign irq_o      = irq_q;

endmodule

// File: rtl/sparrow_dmem_resp.sv
// Data-memory responder for the sparrow core: word RAM with byte-lane stores
// and a 32-byte MMIO window (timer, tohost, status). Loads are combinational.
module sparrow_dmem_resp
  import sparrow_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = 32'h0001_0000,
  parameter int          DMEM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        data_mem_req_i,
  input  logic [31:0] data_mem_addr_i,
  input  logic [1:0]  data_mem_byte_en_i,
  input  logic        data_mem_wr_i,
  input  logic [31:0] data_mem_wr_data_i,
  output logic [31:0] data_mem_rd_data_o,
  output logic        timer_irq_o,
  output logic        tohost_valid_o,
  output logic [31:0] tohost_data_o,
  output logic        err_o
);

  localparam int          IDX_W      = $clog2(DMEM_WORDS);
  localparam logic [31:0] DMEM_BYTES = 32'(4 * DMEM_WORDS);

  logic [31:0] mem_q [DMEM_WORDS];

  logic [31:0] ram_off;
  logic        ram_hit, mmio_hit;
  logic [1:0]  lane;
  logic        is_word;
  logic        acc_err, acc_ok;
  logic [IDX_W-1:0] ram_idx;
  logic [2:0]  mmio_off;
  logic [31:0] ram_rword, ram_shift, ram_rdata, mmio_rdata;
  logic        ram_we, mmio_we;
  logic [3:0]  wr_mask;
  logic [31:0] wr_data_rep;

  logic [63:0] mtime, mtimecmp;
  logic        irq;

  logic        err_q, err_d;
  logic        tohost_valid_q, tohost_valid_d;
  logic [31:0] tohost_data_q, tohost_data_d;

  // Decode: an unsigned offset compare covers both ends of the RAM window.
  assign ram_off  = data_mem_addr_i - DMEM_BASE;
  assign ram_hit  = (data_mem_addr_i >= DMEM_BASE) && (ram_off < DMEM_BYTES);
  assign mmio_hit = (data_mem_addr_i[31:5] == MMIO_BASE[31:5]);
  assign lane     = data_mem_addr_i[1:0];
  assign is_word  = data_mem_byte_en_i[1];
  assign ram_idx  = ram_off[IDX_W+1:2];
  assign mmio_off = data_mem_addr_i[4:2];

  assign acc_err = data_mem_req_i &&
                   (misaligned(data_mem_byte_en_i, lane) ||
                    !(ram_hit || mmio_hit) ||
                    (mmio_hit && !is_word));
  assign acc_ok  = data_mem_req_i && !acc_err;

  assign ram_rword = mem_q[ram_idx];
  assign ram_shift = ram_rword >> {lane, 3'b000};

  always_comb begin
    case (data_mem_byte_en_i)
      SZ_BYTE: ram_rdata = {24'h0, ram_shift[7:0]};
      SZ_HALF: ram_rdata = {16'h0, ram_shift[15:0]};
      default: ram_rdata = ram_rword;
    endcase
  end

  always_comb begin
    case (mmio_off)
      MMIO_MTIME_LO:    mmio_rdata = mtime[31:0];
      MMIO_MTIME_HI:    mmio_rdata = mtime[63:32];
      MMIO_MTIMECMP_LO: mmio_rdata = mtimecmp[31:0];
      MMIO_MTIMECMP_HI: mmio_rdata = mtimecmp[63:32];
      MMIO_TOHOST:      mmio_rdata = tohost_data_q;
      MMIO_STATUS:      mmio_rdata = {30'h0, irq, err_q};
      default:          mmio_rdata = 32'h0;
    endcase
  end

  always_comb begin
    data_mem_rd_data_o = 32'h0;
    if (acc_ok) begin
      data_mem_rd_data_o = ram_hit ? ram_rdata : mmio_rdata;
    end
  end

  assign ram_we      = acc_ok && data_mem_wr_i && ram_hit;
  assign mmio_we     = acc_ok && data_mem_wr_i && mmio_hit;
  assign wr_mask     = lane_mask(data_mem_byte_en_i, lane);
  assign wr_data_rep = replicate(data_mem_byte_en_i, data_mem_wr_data_i);

  // RAM is not reset; a store coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (reset_n && ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) begin
          mem_q[ram_idx][8*i +: 8] <= wr_data_rep[8*i +: 8];
        end
      end
    end
  end

  sparrow_mtimer u_mtimer (
    .clk           (clk),
    .reset_n       (reset_n),
    .wr_mtime_lo_i (mmio_we && (mmio_off == MMIO_MTIME_LO)),
    .wr_mtime_hi_i (mmio_we && (mmio_off == MMIO_MTIME_HI)),
    .wr_cmp_lo_i   (mmio_we && (mmio_off == MMIO_MTIMECMP_LO)),
    .wr_cmp_hi_i   (mmio_we && (mmio_off == MMIO_MTIMECMP_HI)),
    .wdata_i       (data_mem_wr_data_i),
    .mtime_o       (mtime),
    .mtimecmp_o    (mtimecmp),
    .irq_o         (irq)
  );

  always_comb begin
    err_d          = err_q;
    tohost_valid_d = tohost_valid_q;
    tohost_data_d  = tohost_data_q;
    if (acc_err) begin
      err_d = 1'b1;
    end else if (mmio_we && (mmio_off == MMIO_STATUS) && data_mem_wr_data_i[0]) begin
      err_d = 1'b0;
    end
    if (mmio_we && (mmio_off == MMIO_TOHOST)) begin
      tohost_valid_d = 1'b1;
      tohost_data_d  = data_mem_wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q          <= 1'b0;
      tohost_valid_q <= 1'b0;
      tohost_data_q  <= 32'h0;
    end else begin
      err_q          <= err_d;
      tohost_valid_q <= tohost_valid_d;
      tohost_data_q  <= tohost_data_d;
    end
  end

  assign timer_irq_o    = irq;
  assign tohost_valid_o = tohost_valid_q;
  assign tohost_data_o  = tohost_data_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_sparrow_dmem_resp.sv
// Scoreboard bench for sparrow_dmem_resp: byte-array memory model and
// elapsed-cycle timer model; a negedge monitor checks every request cycle.
module tb_sparrow_dmem_resp;

  localparam logic [31:0] DMEM_BASE  = 32'h0001_0000;
  localparam int          DMEM_WORDS = 1024;
  localparam logic [31:0] MMIO_BASE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req;
  logic [31:0] addr;
  logic [1:0]  be;
  logic        wr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq_o, tv_o, err_o;
  logic [31:0] td_o;

  always #5 clk = ~clk;

  sparrow_dmem_resp #(
    .DMEM_BASE (DMEM_BASE),
    .DMEM_WORDS(DMEM_WORDS),
    .MMIO_BASE (MMIO_BASE)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .data_mem_req_i    (req),
    .data_mem_addr_i   (addr),
    .data_mem_byte_en_i(be),
    .data_mem_wr_i     (wr),
    .data_mem_wr_data_i(wd),
    .data_mem_rd_data_o(rd),
    .timer_irq_o       (irq_o),
    .tohost_valid_o    (tv_o),
    .tohost_data_o     (td_o),
    .err_o             (err_o)
  );

  typedef struct {
    string       nm;
    logic [31:0] val;
    bit          skip;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 0;

  // Reference state
  logic [7:0]  mem_m [int];
  logic [63:0] mt_val;
  int          mt_edge;
  int          ecnt;
  logic [63:0] cmp_m;
  logic [31:0] tohost_m;
  bit          err_m;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ecnt <= 0;
    else          ecnt <= ecnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mt_now();
    return mt_val + 64'(ecnt - mt_edge);
  endfunction

  // irq reflects last cycle's mtime; only meaningful when mtime was not just loaded.
  function automatic bit irq_now();
    return (ecnt > mt_edge) && ((mt_now() - 64'd1) >= cmp_m);
  endfunction

  function automatic int nbytes(input logic [1:0] b);
    return (b == 2'b00) ? 1 : (b == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit in_ram(input logic [31:0] a);
    return (a >= DMEM_BASE) && (a < DMEM_BASE + 32'(4 * DMEM_WORDS));
  endfunction

  function automatic bit in_mmio(input logic [31:0] a);
    return (a >> 5) == (MMIO_BASE >> 5);
  endfunction

  function automatic bit acc_bad(input logic [31:0] a, input logic [1:0] b);
    int n;
    n = nbytes(b);
    return ((a % n) != 0) || !(in_ram(a) || in_mmio(a)) || (in_mmio(a) && n != 4);
  endfunction

  function automatic void model_read(input logic [31:0] a, input logic [1:0] b,
                                     output logic [31:0] v, output bit known);
    int off;
    logic [63:0] m;
    v = 32'h0;
    known = 1;
    off = int'(a - DMEM_BASE);
    m = mt_now();
    if (acc_bad(a, b)) return;
    if (in_ram(a)) begin
      for (int i = 0; i < nbytes(b); i++) begin
        if (mem_m.exists(off + i)) v[8*i +: 8] = mem_m[off + i];
        else known = 0;
      end
    end else begin
      case ((a >> 2) & 32'd7)
        32'd0: v = m[31:0];
        32'd1: v = m[63:32];
        32'd2: v = cmp_m[31:0];
        32'd3: v = cmp_m[63:32];
        32'd4: v = tohost_m;
        32'd5: v = {30'h0, irq_now(), err_m};
        default: v = 32'h0;
      endcase
    end
  endfunction

  // One request cycle, called at posedge+1; use_c overrides the model expectation.
  task automatic txn(input string nm, input bit w, input logic [31:0] a, input logic [1:0] b,
                     input logic [31:0] d, input bit use_c = 0, input logic [31:0] cval = 0);
    exp_t        e;
    logic [31:0] v;
    bit          known;
    bit          bad;
    logic [63:0] cur;
    int          nx;
    int          off;
    model_read(a, b, v, known);
    bad = acc_bad(a, b);
    cur = mt_now();
    nx  = ecnt + 1;
    off = int'(a - DMEM_BASE);
    e.nm = nm;
    e.val = use_c ? cval : v;
    e.skip = !use_c && !known;
    exp_q.push_back(e);
    req = 1'b1; wr = w; addr = a; be = b; wd = d;
    @(posedge clk);
    if (bad) begin
      err_m = 1;
    end else if (w) begin
      if (in_ram(a)) begin
        for (int i = 0; i < nbytes(b); i++) mem_m[off + i] = d[8*i +: 8];
      end else begin
        case ((a >> 2) & 32'd7)
          32'd0: begin mt_val = {cur[63:32], d}; mt_edge = nx; end
          32'd1: begin mt_val = {d, cur[31:0]}; mt_edge = nx; end
          32'd2: cmp_m[31:0] = d;
          32'd3: cmp_m[63:32] = d;
          32'd4: tohost_m = d;
          32'd5: if (d[0]) err_m = 0;
          default: ;
        endcase
      end
    end
    #1;
    req = 1'b0; wr = 1'b0; addr = 32'h0; be = 2'b00; wd = 32'h0;
  endtask

  task automatic do_reset();
    mon_en = 0;
    req = 1'b0; wr = 1'b0; addr = 32'h0; be = 2'b00; wd = 32'h0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    exp_q.delete();
    mt_val = 64'h0; mt_edge = 0; cmp_m = '1; tohost_m = 32'h0; err_m = 0;
    #1;
    chk("rst_rd_data", rd, 32'h0);
    chk("rst_irq", irq_o, 1'b0);
    chk("rst_tohost_valid", tv_o, 1'b0);
    chk("rst_tohost_data", td_o, 32'h0);
    chk("rst_err", err_o, 1'b0);
    reset_n = 1'b1;
    mon_en = 1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (req) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_empty: got request with rd %08h, expected none", rd);
        end else begin
          e = exp_q.pop_front();
          if (!e.skip) chk(e.nm, rd, e.val);
        end
      end else begin
        chk("idle_rd_zero", rd, 32'h0);
      end
      chk("err_o", err_o, err_m);
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] a, d;
    logic [1:0]  b;
    int          r;
    req = 1'b0; wr = 1'b0; addr = 32'h0; be = 2'b00; wd = 32'h0;
    do_reset();

    // Timer counts from reset release
    repeat (10) @(posedge clk);
    #1;
    txn("mtime_lo_10", 0, MMIO_BASE + 0, 2'b11, 0, 1, 32'd10);
    txn("cmp_hi_wr", 1, MMIO_BASE + 12, 2'b11, 32'h0);
    txn("cmp_lo_wr", 1, MMIO_BASE + 8, 2'b11, 32'd20);
    repeat (16) begin
      @(negedge clk);
      chk("timer_irq", irq_o, irq_now());
    end
    @(posedge clk); #1;

    // Carry from lo into hi after a write
    txn("mtime_lo_wr", 1, MMIO_BASE + 0, 2'b11, 32'hFFFF_FFFF);
    txn("mtime_hi_wr", 1, MMIO_BASE + 4, 2'b11, 32'h0);
    @(posedge clk); #1;
    txn("carry_lo", 0, MMIO_BASE + 0, 2'b11, 0, 1, 32'h0);
    txn("carry_hi", 0, MMIO_BASE + 4, 2'b11, 0, 1, 32'h1);

    // tohost, then asynchronous reset mid-cycle
    txn("tohost_wr", 1, MMIO_BASE + 16, 2'b11, 32'h1);
    chk("tohost_valid", tv_o, 1'b1);
    chk("tohost_data", td_o, 32'h1);
    txn("unmapped_ld", 0, 32'h0000_0000, 2'b11, 0);
    chk("err_before_rst", err_o, 1'b1);
    chk("irq_before_rst", irq_o, irq_now());
    chk("irq_high_before_rst", irq_o, 1'b1);
    mon_en = 0;
    #1 reset_n = 1'b0;
    #1;
    chk("async_tohost_valid", tv_o, 1'b0);
    chk("async_tohost_data", td_o, 32'h0);
    chk("async_err", err_o, 1'b0);
    chk("async_irq", irq_o, 1'b0);
    do_reset();

    // RAM lanes
    txn("st_word", 1, 32'h0001_0004, 2'b11, 32'hDEAD_BEEF);
    txn("ld_b4", 0, 32'h0001_0004, 2'b00, 0, 1, 32'h0000_00EF);
    txn("ld_b5", 0, 32'h0001_0005, 2'b00, 0, 1, 32'h0000_00BE);
    txn("ld_b6", 0, 32'h0001_0006, 2'b00, 0, 1, 32'h0000_00AD);
    txn("ld_b7", 0, 32'h0001_0007, 2'b00, 0, 1, 32'h0000_00DE);
    txn("ld_h6", 0, 32'h0001_0006, 2'b01, 0, 1, 32'h0000_DEAD);
    txn("st_b5_old", 1, 32'h0001_0005, 2'b00, 32'h0000_0055, 1, 32'h0000_00BE);
    txn("ld_w_merged", 0, 32'h0001_0004, 2'b11, 0, 1, 32'hDEAD_55EF);
    txn("st_w_old", 1, 32'h0001_0004, 2'b11, 32'h0BAD_F00D, 1, 32'hDEAD_55EF);
    txn("ld_w_new", 0, 32'h0001_0004, 2'b11, 0, 1, 32'h0BAD_F00D);
    txn("st_h2", 1, 32'h0001_0006, 2'b01, 32'hFFFF_1234);
    txn("ld_w_h2", 0, 32'h0001_0004, 2'b11, 0, 1, 32'h1234_F00D);
    txn("st_first", 1, 32'h0001_0000, 2'b11, 32'h1111_1111);
    txn("st_last", 1, 32'h0001_0FFC, 2'b11, 32'hA5A5_0FFC);
    txn("ld_last", 0, 32'h0001_0FFC, 2'b11, 0, 1, 32'hA5A5_0FFC);
    txn("ld_last_b3", 0, 32'h0001_0FFF, 2'b00, 0, 1, 32'h0000_00A5);

    // Store in flight when reset asserts is dropped
    mon_en = 0;
    req = 1'b1; wr = 1'b1; addr = 32'h0001_0004; be = 2'b11; wd = 32'h1234_5678;
    #1 reset_n = 1'b0;
    @(posedge clk); #1;
    do_reset();
    txn("ld_after_rst_store", 0, 32'h0001_0004, 2'b11, 0, 1, 32'h1234_F00D);

    // Error paths
    txn("ld_misaligned", 0, 32'h0001_0002, 2'b11, 0, 1, 32'h0);
    txn("status_err", 0, MMIO_BASE + 20, 2'b11, 0, 1, 32'h1);
    txn("status_w0", 1, MMIO_BASE + 20, 2'b11, 32'h2);
    txn("status_w1c", 1, MMIO_BASE + 20, 2'b11, 32'h1);
    txn("status_clear", 0, MMIO_BASE + 20, 2'b11, 0, 1, 32'h0);
    txn("st_unmapped", 1, 32'h0000_0000, 2'b11, 32'hFFFF_FFFF, 1, 32'h0);
    txn("ram_untouched", 0, 32'h0001_0000, 2'b11, 0, 1, 32'h1111_1111);
    txn("ld_past_end", 0, 32'h0001_1000, 2'b11, 0, 1, 32'h0);
    txn("ld_below_base", 0, 32'h0000_FFFC, 2'b11, 0, 1, 32'h0);
    txn("ld_half_odd", 0, 32'h0001_0005, 2'b01, 0, 1, 32'h0);
    txn("mmio_byte", 0, MMIO_BASE + 0, 2'b00, 0, 1, 32'h0);
    txn("mmio_misaligned", 0, MMIO_BASE + 2, 2'b11, 0, 1, 32'h0);
    txn("status_w1c2", 1, MMIO_BASE + 20, 2'b11, 32'h1);
    txn("rsvd_wr", 1, MMIO_BASE + 24, 2'b11, 32'hFFFF_FFFF);
    txn("rsvd_rd", 0, MMIO_BASE + 28, 2'b11, 0, 1, 32'h0);
    txn("be10_word", 0, 32'h0001_0000, 2'b10, 0, 1, 32'h1111_1111);

    // Randomized traffic against the model
    for (int i = 0; i < 16; i++) begin
      txn("rnd_init", 1, DMEM_BASE + 32'h100 + 32'(4 * i), 2'b11, $urandom);
    end
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 19);
      b = 2'($urandom_range(0, 3));
      a = DMEM_BASE + 32'h100 + 32'($urandom_range(0, 63));
      d = $urandom;
      if (r < 7) begin
        txn("rnd_st", 1, a, b, d);
      end else if (r < 17) begin
        txn("rnd_ld", 0, a, b, 0);
      end else if (r == 17) begin
        a = ($urandom_range(0, 1) == 1) ? 32'h0001_1000 + 32'($urandom_range(0, 255))
                                         : 32'($urandom_range(0, 32'hFFFF));
        txn("rnd_unmapped", $urandom_range(0, 1) == 1, a, b, d);
      end else if (r == 18) begin
        txn("rnd_mmio_rd", 0, MMIO_BASE + 32'(4 * $urandom_range(0, 7)), b, 0);
      end else begin
        txn("rnd_w1c", 1, MMIO_BASE + 20, 2'b11, 32'h1);
      end
    end

    @(posedge clk); #1;
    mon_en = 0;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
